video_mem_arbiter: RTL and testbench

//  Shares the single-port 16K x 12 video memory (1-cycle synchronous read latency) between the

---
 rtl/video_mem_pkg.sv | 15 +
 rtl/video_mem_arb_starve_guard.sv | 34 +++
 rtl/video_mem_arbiter.sv | 92 +++++++++
 tb/tb_video_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mem_pkg.sv
// Shared constants and FSM state type for the video memory arbiter.
// Address/data widths match the 16K x 12 video RAM.
package video_mem_pkg;

   localparam int VMEM_ADDR_W       = 14;
   localparam int VMEM_DATA_W       = 12;
   localparam int VMEM_STARVE_LIMIT = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      ACK     = 2'd2
   } arb_state_t;

endpackage

// File: rtl/video_mem_arb_starve_guard.sv
// Counts consecutive denied CPU cycles and forces a CPU slot at STARVE_LIMIT.
// Only instantiated when VIDEO_MEM_ARB_STARVE_GUARD_EN is defined.
module video_mem_arb_starve_guard
   import video_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = VMEM_STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic cpu_req,
   input  logic cpu_grant,
   output logic force_cpu
);

   localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] count;

   // Saturates at LIMIT so the force flag stays up until the CPU is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (cpu_grant) begin
         count <= '0;
      end else if (idle && cpu_req && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign force_cpu = (count == LIMIT);

endmodule

// File: rtl/video_mem_arbiter.sv
// Shares the single-port video RAM between video fetch (priority) and a CPU req/ack port.
// Optional starvation guard enabled by VIDEO_MEM_ARB_STARVE_GUARD_EN.
module video_mem_arbiter
   import video_mem_pkg::*;
#(
   parameter int ADDR_W = VMEM_ADDR_W,
   parameter int DATA_W = VMEM_DATA_W
`ifdef VIDEO_MEM_ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = VMEM_STARVE_LIMIT
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q
);

   arb_state_t state;
   logic       force_cpu;
   logic       cpu_grant;
   logic       vid_grant;

`ifdef VIDEO_MEM_ARB_STARVE_GUARD_EN
   video_mem_arb_starve_guard #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_guard (
      .clk       (clk),
      .rst       (rst),
      .idle      (state == IDLE),
      .cpu_req   (cpu_req),
      .cpu_grant (cpu_grant),
      .force_cpu (force_cpu)
   );
`else
   assign force_cpu = 1'b0;
`endif

   assign cpu_grant = cpu_req && (state == IDLE) && (!vid_req || force_cpu);
   assign vid_grant = vid_req && !cpu_grant;

   // Idle slots still present the video address; writes are blocked during reset.
   always_comb begin
      mem_addr  = vid_addr;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (cpu_grant) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we & rst;
      end
   end

   assign vid_data = mem_q;
   assign cpu_ack  = (state == ACK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         vid_valid <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         vid_valid <= vid_grant;
         case (state)
            IDLE: begin
               if (cpu_grant) begin
                  state <= cpu_we ? ACK : RD_WAIT;
               end
            end
            RD_WAIT: begin
               cpu_rdata <= mem_q;
               state     <= ACK;
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Scoreboard bench for video_mem_arbiter: random video/CPU traffic against a cycle-count model.
`timescale 1ns/1ps
module tb_video_mem_arbiter;

   localparam int AW = 14;
   localparam int DW = 12;
`ifdef VIDEO_MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
   localparam int LIMIT = 4;
`else
   localparam bit GUARD = 1'b0;
   localparam int LIMIT = 0;
`endif

   typedef struct {
      int            cyc;
      bit            rd;
      logic [DW-1:0] d;
   } exp_t;

   typedef struct {
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } op_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_q = '0;

`ifdef VIDEO_MEM_ARB_STARVE_GUARD_EN
   video_mem_arbiter #(.STARVE_LIMIT(4)) dut (
`else
   video_mem_arbiter dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_q     (mem_q)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
      return DW'((32'(a) * 32'd37) ^ 32'h5A5);
   endfunction

   // Single-port RAM with one-cycle synchronous read.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit            wr  [0:(1<<AW)-1];
   int            n_we_seen = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      mem_q <= wr[mem_addr] ? mem[mem_addr] : seed_val(mem_addr);
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr[mem_addr]  <= 1'b1;
         n_we_seen++;
      end
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [int];
   exp_t          vid_q[$];
   exp_t          cpu_q[$];
   op_t           ops_q[$];
   op_t           cur = '{we: 1'b0, a: '0, d: '0};
   logic [DW-1:0] exp_rdata = '0;
   bit            req_on = 1'b0;
   bit            op_granted = 1'b0;
   int            next_ok = 0;
   int            denied = 0;
   int            n_wr = 0;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed_val(a);
   endfunction

   // Monitor: compares registered outputs each cycle against the scoreboard.
   always @(negedge clk) begin : monitor
      bit ev;
      bit ea;
      ev = (vid_q.size() > 0) && (vid_q[0].cyc == cyc);
      chk("vid_valid", 32'(vid_valid), 32'(ev));
      if (ev) begin
         if (vid_valid) chk("vid_data", 32'(vid_data), 32'(vid_q[0].d));
         void'(vid_q.pop_front());
      end
      ea = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc);
      chk("cpu_ack", 32'(cpu_ack), 32'(ea));
      if (ea) begin
         if (cpu_q[0].rd) exp_rdata = cpu_q[0].d;
         void'(cpu_q.pop_front());
      end
      chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
   end

   // One cycle of stimulus; entered and left on a falling edge.
   task automatic run_cycle(input bit vr, input logic [AW-1:0] va);
      bit g;
      bit frc;
      bit idle_req;
      if (req_on && cpu_ack) begin
         req_on     = 1'b0;
         op_granted = 1'b0;
      end else if (!req_on && !cpu_ack && ops_q.size() > 0) begin
         cur        = ops_q.pop_front();
         req_on     = 1'b1;
         op_granted = 1'b0;
      end
      vid_req   = vr;
      vid_addr  = va;
      cpu_req   = req_on;
      cpu_we    = cur.we;
      cpu_addr  = cur.a;
      cpu_wdata = cur.d;

      frc      = GUARD && (denied >= LIMIT);
      idle_req = req_on && !op_granted && (cyc >= next_ok);
      g        = idle_req && (!vr || frc);
      if (idle_req && !g && denied < LIMIT) denied++;
      if (g) begin
         denied     = 0;
         op_granted = 1'b1;
         if (cur.we) begin
            ref_mem[int'(cur.a)] = cur.d;
            cpu_q.push_back('{cyc: cyc + 1, rd: 1'b0, d: '0});
            next_ok = cyc + 2;
            n_wr++;
         end else begin
            cpu_q.push_back('{cyc: cyc + 2, rd: 1'b1, d: ref_rd(cur.a)});
            next_ok = cyc + 3;
         end
      end
      if (vr && !g) vid_q.push_back('{cyc: cyc + 1, rd: 1'b0, d: ref_rd(va)});

      #1;
      chk("mem_we", 32'(mem_we), 32'(g && cur.we));
      chk("mem_addr", 32'(mem_addr), 32'(g ? cur.a : va));
      if (g && cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.d));
      @(negedge clk);
   endtask

   task automatic drain();
      int b;
      b = 0;
      while ((ops_q.size() > 0 || req_on || vid_q.size() > 0 || cpu_q.size() > 0) && b < 200) begin
         run_cycle(1'b0, AW'($urandom));
         b++;
      end
      chk("drain_in_budget", 32'(b < 200), 32'd1);
   endtask

   task automatic do_reset(input int n);
      #2;
      rst = 1'b0;
      vid_q.delete();
      cpu_q.delete();
      exp_rdata  = '0;
      req_on     = 1'b0;
      op_granted = 1'b0;
      next_ok    = 0;
      denied     = 0;
      vid_req    = 1'b1;
      vid_addr   = 14'h0AAA;
      cpu_req    = 1'b1;
      cpu_we     = 1'b1;
      cpu_addr   = 14'h0055;
      cpu_wdata  = 12'hFFF;
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      repeat (n) @(negedge clk);
      vid_req = 1'b0;
      cpu_req = 1'b0;
      #2;
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int acks_before;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);

      // Continuous video scan, addresses 0..15.
      for (int i = 0; i < 16; i++) run_cycle(1'b1, AW'(i));
      run_cycle(1'b0, '0);

      // CPU write then read back with video idle.
      ops_q.push_back('{we: 1'b1, a: 14'h0123, d: 12'h3A5});
      ops_q.push_back('{we: 1'b0, a: 14'h0123, d: 12'h000});
      drain();
      run_cycle(1'b0, '0);
      chk("readback_held", 32'(cpu_rdata), 32'h3A5);

      // Pending read blocked by 10 video cycles.
      ops_q.push_back('{we: 1'b0, a: 14'h0123, d: 12'h000});
      for (int i = 0; i < 10; i++) run_cycle(1'b1, AW'($urandom));
      drain();

      // Alternating video with back-to-back writes.
      for (int i = 0; i < 8; i++)
         ops_q.push_back('{we: 1'b1, a: 14'h0100 + AW'(i), d: DW'($urandom)});
      for (int i = 0; i < 40; i++) run_cycle(i % 2 == 0, 14'h0100 + AW'($urandom_range(0, 7)));
      drain();

      // Reset while a read is in RD_WAIT, then normal service.
      ops_q.push_back('{we: 1'b0, a: 14'h0101, d: 12'h000});
      run_cycle(1'b0, '0);
      do_reset(3);
      ops_q.push_back('{we: 1'b1, a: 14'h0200, d: 12'h5C3});
      ops_q.push_back('{we: 1'b0, a: 14'h0200, d: 12'h000});
      drain();

      // Video stuck high with a CPU write pending.
      acks_before = n_wr;
      ops_q.push_back('{we: 1'b1, a: 14'h0300, d: 12'h1E7});
      for (int i = 0; i < 60; i++) run_cycle(1'b1, AW'($urandom));
      chk("starve_req_still_held", 32'(req_on), 32'(!GUARD));
      chk("starve_writes_done", 32'(n_we_seen - acks_before), 32'(GUARD ? 1 : 0));
      drain();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if (ops_q.size() == 0 && $urandom_range(0, 2) == 0)
            ops_q.push_back('{we: 1'($urandom), a: 14'h0400 + AW'($urandom_range(0, 31)), d: DW'($urandom)});
         run_cycle(1'($urandom_range(0, 1)), 14'h0400 + AW'($urandom_range(0, 31)));
      end
      drain();

      foreach (ref_mem[a]) begin
         chk("mem_content", 32'(wr[a] ? mem[a] : seed_val(AW'(a))), 32'(ref_mem[a]));
      end
      chk("write_count", 32'(n_we_seen), 32'(n_wr));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL global_timeout: simulation still running at cycle %0d, limit 100000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
